crc_framer: RTL and testbench
=============================

# crc_framer

Frame-level controller for the team's CRC8 engine (G(x) = x^8+x^4+x^3+x^2+1, poly 0x1d, init 0xFF, reflected in/out, xorout 0x00, check 0x97). It accepts a byte stream delimited by a last flag and passes each byte through with one cycle of latency. After the last byte it appends the CRC byte. It sequences the engine's init and valid inputs so each frame starts from 0xFF, and it enforces a maximum frame length and an inter-frame gap. It sits between the packet builder and the serializer on the transmit path.

## Interface
- MAX_LEN, 1500: maximum data bytes per frame, excluding CRC; legal range 1..65535
- IFG, 2: idle cycles after the CRC byte before the next frame is accepted; legal range 0..255
- clk  in  1  single clock; everything is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- axiiv  in  1  input byte valid
- axiid  in  8  input byte
- axiil  in  1  last byte of frame; qualified by axiiv
- axiir  out  1  ready; a byte transfers when axiiv && axiir
- axiov  out  1  output byte valid
- axiod  out  8  output byte: data or CRC
- axiol  out  1  high with the CRC byte
- err  out  1  one-cycle pulse when a frame is truncated at MAX_LEN
- frames  out  16  count of completed frames; wraps at 0xFFFF -> 0

## Operation
- Instantiates one CRC8 engine. Engine init is driven high while rst_n is low and during the CRC state. Engine valid equals accept (axiiv && axiir). Engine data equals axiid.
- States:
  - IDLE: axiir=1. An accept with axiil=0 -> DATA. An accept with axiil=1 -> CRC.
  - DATA: axiir=1. An accept with axiil=1, or an accept that makes byte count == MAX_LEN -> CRC.
  - CRC: axiir=0. Output registers load the engine CRC byte. The engine re-inits to 0xFF. frames increments. Next state is GAP if IFG>0, otherwise IDLE.
  - GAP: axiir=0. Counts IFG cycles, then -> IDLE.
- axiir is combinational from state and is forced to 0 while rst_n is low.
- Byte counter:
  - Width $clog2(MAX_LEN+1).
  - Cleared when entering CRC.
  - Increments on each accept.
- Truncation: when the MAX_LEN-th byte is accepted with axiil=0:
  - That byte is forwarded normally.
  - CRC is appended as usual.
  - err pulses in the CRC-state cycle.
  - The next byte the upstream presents starts a new frame.
- Accepted byte with axiil=1 that is also the MAX_LEN-th byte: normal termination, no err.
- MAX_LEN=1: every accepted byte ends a frame. err pulses only when axiil=0.
- axiiv low in IDLE or DATA: no engine update and no output (axiov=0). The frame stays open indefinitely.
- Inputs while axiir=0 are ignored. Upstream must hold them.

## Timing
- Reset values while rst_n is low and after release:
  - state IDLE
  - axiov=0, axiod=0x00, axiol=0, err=0, frames=0, axiir=0
  - engine holds 0xFF
- After the first clk edge with rst_n high, axiir=1.
- Data latency: a byte accepted at edge k appears on axiod with axiov=1, axiol=0 after edge k.
- CRC timing: last byte accepted at edge k. State is CRC during cycle k..k+1. The CRC byte appears after edge k+1 with axiov=axiol=1. Output is contiguous with the last data byte.
- axiir returns to 1 exactly IFG+1 cycles after the last accept: the CRC cycle plus IFG gap cycles. Back-to-back frames at IFG=0 lose exactly one input cycle each.
- Maximum throughput: MAX_LEN bytes per MAX_LEN+1+IFG cycles.
- err and frames update on the same edge that presents the CRC byte.
- Reset assertion mid-frame:
  - Outputs clear immediately.
  - The partial frame is dropped and no CRC is emitted.
  - The engine re-inits.
  - frames is not incremented.

## Test plan
- Send ASCII "123456789" (0x31..0x39, last on 0x39), IFG=2 -> output is the 9 bytes then 0x97 with axiol=1; axiir is low for 3 cycles; frames=1.
- Send two back-to-back "123456789" frames at IFG=0 -> both CRC bytes are 0x97, confirming re-init; axiir is low for exactly 1 cycle between frames; frames=2.
- MAX_LEN=4, send 6 bytes with no last -> 4 bytes, CRC, err pulse, then a new frame starting at byte 5; frames counts both frames.
- Random axiiv gaps inside "123456789" -> CRC still 0x97; axiov is low in each gap cycle.
- Assert rst_n low after 5 bytes of a frame, then send "123456789" -> no CRC after the partial frame; new frame CRC is 0x97; frames=1.
- Preload frames=0xFFFF via 65535 one-byte frames (or force), then send one more frame -> frames=0x0000.

Source files
------------

// File: rtl/crc_framer.sv
// crc_framer: passes a last-delimited byte stream through with one cycle of
// latency, appends a reflected CRC8 (poly 0x1d, init 0xFF) after each frame,
// truncates frames at MAX_LEN and inserts IFG idle cycles between frames.

module crc8_engine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);
    logic [7:0] crc_q, crc_d;
    logic [7:0] mix;

    // Next CRC: init wins over data; one byte folded in LSB-first per valid.
    always_comb begin
        crc_d = crc_q;
        mix   = crc_q ^ data_i;
        if (init_i) begin
            crc_d = '1;
        end else if (valid_i) begin
            for (int unsigned b = 0; b < 8; b++) begin
                mix = mix[0] ? ((mix >> 1) ^ 8'hB8) : (mix >> 1);
            end
            crc_d = mix;
        end
    end

    // CRC register, holds 0xFF through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '1;
        else        crc_q <= crc_d;
    end

    assign crc_o = crc_q;
endmodule

module crc_framer #(
    parameter int MAX_LEN = 1500,
    parameter int IFG     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [7:0]  axiid,
    input  logic        axiil,
    output logic        axiir,
    output logic        axiov,
    output logic [7:0]  axiod,
    output logic        axiol,
    output logic        err,
    output logic [15:0] frames
);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_GAP} state_t;

    state_t        state_q, state_d;
    logic          en_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gap_q, gap_d;
    logic          trunc_q, trunc_d;
    logic          ov_q, ov_d, ol_q, ol_d, err_q, err_d;
    logic [7:0]    od_q, od_d;
    logic [15:0]   frames_q, frames_d;
    logic          accept, at_max, open_st, eng_init;
    logic [7:0]    crc;

    assign open_st  = (state_q == S_IDLE) || (state_q == S_DATA);
    // en_q keeps ready low until the first edge after reset release.
    assign axiir    = rst_n && en_q && open_st;
    assign accept   = axiiv && axiir;
    assign at_max   = (int'(cnt_q) + 1 == MAX_LEN);
    assign eng_init = !rst_n || (state_q == S_CRC);

    crc8_engine u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .init_i  (eng_init),
        .valid_i (accept),
        .data_i  (axiid),
        .crc_o   (crc)
    );

    // Next-state, byte/gap counters and registered output stage.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        trunc_d  = trunc_q;
        ov_d     = 1'b0;
        ol_d     = 1'b0;
        od_d     = od_q;
        err_d    = 1'b0;
        frames_d = frames_q;
        case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    ov_d = 1'b1;
                    od_d = axiid;
                    if (axiil || at_max) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                        trunc_d = !axiil;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            S_CRC: begin
                ov_d     = 1'b1;
                ol_d     = 1'b1;
                od_d     = crc;
                err_d    = trunc_q;
                trunc_d  = 1'b0;
                frames_d = frames_q + 16'd1;
                gap_d    = '0;
                state_d  = (IFG > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                gap_d = gap_q + 8'd1;
                if (int'(gap_q) + 1 >= IFG) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            cnt_q    <= '0;
            gap_q    <= '0;
            trunc_q  <= 1'b0;
            ov_q     <= 1'b0;
            ol_q     <= 1'b0;
            od_q     <= '0;
            err_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= 1'b1;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            trunc_q  <= trunc_d;
            ov_q     <= ov_d;
            ol_q     <= ol_d;
            od_q     <= od_d;
            err_q    <= err_d;
            frames_q <= frames_d;
        end
    end

    assign axiov  = ov_q;
    assign axiod  = od_q;
    assign axiol  = ol_q;
    assign err    = err_q;
    assign frames = frames_q;
endmodule

// File: tb/tb_crc_framer.sv
// Bench for crc_framer: four instances with different MAX_LEN/IFG driven by
// directed and random frames, checked each cycle against a frame-level model.

module tb_crc_framer;
    localparam int N = 4;

    function automatic int ml_of(input int g);
        case (g)
            0: return 9;
            1: return 9;
            2: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int ifg_of(input int g);
        case (g)
            0: return 2;
            1: return 0;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]        axiiv, axiil, axiir, axiov, axiol, err;
    logic [N-1:0][7:0]   axiid, axiod;
    logic [N-1:0][15:0]  frames;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        crc_framer #(.MAX_LEN(ml_of(g)), .IFG(ifg_of(g))) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .axiiv  (axiiv[g]),
            .axiid  (axiid[g]),
            .axiil  (axiil[g]),
            .axiir  (axiir[g]),
            .axiov  (axiov[g]),
            .axiod  (axiod[g]),
            .axiol  (axiol[g]),
            .err    (err[g]),
            .frames (frames[g])
        );
    end

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got 0x%0h want 0x%0h at %0t", name, idx, got, exp, $time);
        end
    endtask

    // Textbook reflected CRC: reverse each byte, MSB-first division by 0x1d, reverse result.
    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = x[7-k];
        return r;
    endfunction

    function automatic logic [7:0] crc_ref(input byte unsigned q[$]);
        logic [7:0] c;
        c = 8'hFF;
        foreach (q[k]) begin
            c = c ^ rev8(q[k]);
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h1D) : (c << 1);
        end
        return rev8(c);
    endfunction

    // Frame-level model state.
    bit           m_en[N], m_rdy[N], m_pend[N], m_trunc[N];
    int           m_block[N];
    byte unsigned m_fq[N][$];
    logic         e_ov[N], e_ol[N], e_err[N];
    logic [7:0]   e_od[N];
    logic [15:0]  e_frames[N];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < N; i++) begin
            bit acc;
            if (!rst_n) begin
                m_en[i] = 0; m_rdy[i] = 0; m_pend[i] = 0; m_trunc[i] = 0; m_block[i] = 0;
                m_fq[i].delete();
                e_ov[i] = 0; e_ol[i] = 0; e_err[i] = 0; e_od[i] = 8'h00; e_frames[i] = 16'h0;
            end else begin
                acc = axiiv[i] && m_rdy[i];
                e_ov[i] = 0; e_ol[i] = 0; e_err[i] = 0;
                if (m_pend[i]) begin
                    e_ov[i] = 1; e_ol[i] = 1;
                    e_od[i] = crc_ref(m_fq[i]);
                    e_err[i] = m_trunc[i];
                    e_frames[i] = e_frames[i] + 16'd1;
                    m_fq[i].delete();
                    m_block[i] = ifg_of(i);
                    m_pend[i] = 0;
                end else begin
                    if (m_block[i] > 0) m_block[i]--;
                    if (acc) begin
                        e_ov[i] = 1;
                        e_od[i] = axiid[i];
                        m_fq[i].push_back(axiid[i]);
                        if (axiil[i] || m_fq[i].size() == ml_of(i)) begin
                            m_pend[i] = 1;
                            m_trunc[i] = !axiil[i];
                        end
                    end
                end
                m_en[i] = 1;
                m_rdy[i] = m_en[i] && !m_pend[i] && (m_block[i] == 0);
            end
        end
    end

    int         low_run[N], last_low[N], err_seen[N];
    logic [7:0] last_crc[N];

    // Per-cycle comparison of every instance against the model.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("axiov", i, axiov[i], e_ov[i]);
            chk("axiol", i, axiol[i], e_ol[i]);
            chk("err", i, err[i], e_err[i]);
            chk("frames", i, frames[i], e_frames[i]);
            chk("axiir", i, axiir[i], m_rdy[i] && rst_n);
            if (e_ov[i]) chk("axiod", i, axiod[i], e_od[i]);
            if (axiov[i] && axiol[i]) last_crc[i] = axiod[i];
            if (err[i]) err_seen[i]++;
            if (rst_n) begin
                if (!axiir[i]) low_run[i]++;
                else begin
                    if (low_run[i] > 0) last_low[i] = low_run[i];
                    low_run[i] = 0;
                end
            end
        end
    end

    task automatic idle(input int i, input int n);
        repeat (n) begin
            @(negedge clk);
            axiiv[i] = 1'b0;
            axiil[i] = 1'b0;
        end
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit last);
        int w;
        w = 0;
        @(negedge clk);
        axiiv[i] = 1'b1; axiid[i] = d; axiil[i] = last;
        while (!axiir[i] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            total++; bad++;
            $display("FAIL ready_wait[%0d]: axiir stayed 0 want 1", i);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input int i, input byte unsigned b[$], input bit with_last, input int maxgap);
        foreach (b[k]) begin
            send(i, b[k], with_last && (k == b.size() - 1));
            if (maxgap > 0) idle(i, $urandom_range(0, maxgap));
        end
        idle(i, 1);
    endtask

    byte unsigned s123[$];
    byte unsigned tmp[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        axiiv = '0; axiil = '0; axiid = '0;
        for (int i = 0; i < N; i++) begin
            low_run[i] = 0; last_low[i] = 0; err_seen[i] = 0; last_crc[i] = 8'h00;
        end
        for (int k = 0; k < 9; k++) s123.push_back(byte'(8'h31 + k));

        // Pin the model with hand-computed values.
        chk("model_check", 0, crc_ref(s123), 8'h97);
        tmp = '{8'h00};
        chk("model_zero", 0, crc_ref(tmp), 8'h23);

        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_axiov", i, axiov[i], 1'b0);
            chk("rst_axiod", i, axiod[i], 8'h00);
            chk("rst_axiol", i, axiol[i], 1'b0);
            chk("rst_err", i, err[i], 1'b0);
            chk("rst_frames", i, frames[i], 16'h0);
            chk("rst_axiir", i, axiir[i], 1'b0);
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chk("axiir_before_edge", i, axiir[i], 1'b0);
        @(posedge clk); #2;
        for (int i = 0; i < N; i++) chk("axiir_after_edge", i, axiir[i], 1'b1);

        // Check value frame, IFG=2.
        send_frame(0, s123, 1, 0);
        idle(0, 6);
        chk("crc_123", 0, last_crc[0], 8'h97);
        chk("frames_123", 0, frames[0], 16'd1);
        chk("ready_low_ifg2", 0, last_low[0], 3);

        // Back-to-back at IFG=0.
        send_frame(1, s123, 1, 0);
        send_frame(1, s123, 1, 0);
        idle(1, 4);
        chk("crc_b2b", 1, last_crc[1], 8'h97);
        chk("frames_b2b", 1, frames[1], 16'd2);
        chk("ready_low_ifg0", 1, last_low[1], 1);

        // Truncation at MAX_LEN=4, then bytes 5..6 open a new frame closed by byte 7.
        for (int k = 0; k < 6; k++) send(2, 8'h10 + k[7:0], 0);
        send(2, 8'h16, 1);
        idle(2, 6);
        chk("trunc_err", 2, err_seen[2], 1);
        chk("trunc_frames", 2, frames[2], 16'd2);
        tmp = '{8'h14, 8'h15, 8'h16};
        chk("trunc_crc2", 2, last_crc[2], crc_ref(tmp));

        // MAX_LEN=1: err only when last is low.
        send(3, 8'hA5, 0); idle(3, 3);
        send(3, 8'h5A, 1); idle(3, 3);
        chk("ml1_err", 3, err_seen[3], 1);
        chk("ml1_frames", 3, frames[3], 16'd2);
        tmp = '{8'h5A};
        chk("ml1_crc", 3, last_crc[3], crc_ref(tmp));

        // Random valid gaps inside the check frame.
        send_frame(0, s123, 1, 2);
        idle(0, 6);
        chk("crc_gaps", 0, last_crc[0], 8'h97);
        chk("frames_gaps", 0, frames[0], 16'd2);

        // Random frames on random instances.
        for (int f = 0; f < 40; f++) begin
            int i;
            int len;
            i = $urandom_range(0, N - 1);
            len = $urandom_range(1, 12);
            tmp.delete();
            for (int k = 0; k < len; k++) tmp.push_back(byte'($urandom_range(0, 255)));
            send_frame(i, tmp, ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
        end
        for (int i = 0; i < N; i++) begin
            send(i, 8'hC3, 1);
            idle(i, 1);
        end
        idle(0, 8);

        // Reset in the middle of a frame.
        last_crc[0] = 8'h00;
        for (int k = 0; k < 5; k++) send(0, 8'h41 + k[7:0], 0);
        #2;
        rst_n = 1'b0;
        axiiv[0] = 1'b0;
        #1;
        chk("midrst_axiov", 0, axiov[0], 1'b0);
        chk("midrst_axiod", 0, axiod[0], 8'h00);
        chk("midrst_frames", 0, frames[0], 16'h0);
        chk("midrst_axiir", 0, axiir[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(0, 4);
        chk("midrst_no_crc", 0, last_crc[0], 8'h00);
        send_frame(0, s123, 1, 0);
        idle(0, 6);
        chk("midrst_crc", 0, last_crc[0], 8'h97);
        chk("midrst_frames1", 0, frames[0], 16'd1);

        // Frame counter wrap.
        @(negedge clk);
        force gen_dut[1].dut.frames_q = 16'hFFFF;
        e_frames[1] = 16'hFFFF;
        @(negedge clk);
        release gen_dut[1].dut.frames_q;
        chk("wrap_preload", 1, frames[1], 16'hFFFF);
        tmp = '{8'h77};
        send_frame(1, tmp, 1, 0);
        idle(1, 4);
        chk("wrap_frames", 1, frames[1], 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
